// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: control bundle between the multicycle sequencer and its datapath.
// Latency: none, wires only.
// Backpressure: none; the datapath always accepts the control word presented each cycle.
// Ports: Instr/Zero flow datapath -> control; ALU op, mux selects, write enables,
//        IllegalInstr and InstrCount flow control -> datapath.
interface multicycle_control_fsm_if #(
  parameter int OP_WIDTH  = 4,
  parameter int CNT_WIDTH = 32
);
  logic [31:0]          Instr;
  logic                 Zero;
  logic [OP_WIDTH-1:0]  ALUControl;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ResultSrc;
  logic                 AdrSrc;
  logic [2:0]           ImmSrc;
  logic                 IRWrite;
  logic                 PCWrite;
  logic                 RegWrite;
  logic                 MemWrite;
  logic                 IllegalInstr;
  logic [CNT_WIDTH-1:0] InstrCount;

  // Control unit side.
  modport master (
    input  Instr, Zero,
    output ALUControl, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ImmSrc,
           IRWrite, PCWrite, RegWrite, MemWrite, IllegalInstr, InstrCount
  );

  // Datapath side.
  modport slave (
    output Instr, Zero,
    input  ALUControl, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ImmSrc,
           IRWrite, PCWrite, RegWrite, MemWrite, IllegalInstr, InstrCount
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: main sequencer of the multicycle RV32I core, drives the shared ALU.
// Latency: R/I 4, lw 5, sw 4, branch 3, jal 4 cycles from FETCH to the next FETCH.
// Backpressure: none; advances every cycle, ERROR holds until rst.
// Ports: clk/rst plain; bus (master) carries Instr/Zero in, control word, sticky
//        IllegalInstr and the wrapping retired-instruction count out.
module multicycle_control_fsm #(
  parameter int OP_WIDTH  = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_control_fsm_if.master bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [OP_WIDTH-1:0] ALU_ADD = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] ALU_SUB = OP_WIDTH'(1);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_ERROR
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 illegal_q, illegal_d;

  logic [OP_WIDTH-1:0]  alu_ctrl;
  logic [1:0]           src_a, src_b, result_src;
  logic                 adr_src, ir_write, pc_write, reg_write, mem_write, retire;
  logic [2:0]           imm_src;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  assign opcode    = bus.Instr[6:0];
  assign funct3    = bus.Instr[14:12];
  assign funct7_b5 = bus.Instr[30];

  // Register/immediate fields are consumed by the datapath, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.Instr[31], bus.Instr[29:15], bus.Instr[11:7]};

  // SUB exists only for register-register ops; SRA/SRL is chosen by bit 30 in both forms.
  function automatic logic [OP_WIDTH-1:0] alu_decode(input logic [2:0] f3,
                                                      input logic       b30,
                                                      input logic       is_r);
    logic [OP_WIDTH-1:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000: op = (is_r && b30) ? ALU_SUB : ALU_ADD;
      3'b001: op = OP_WIDTH'(2);
      3'b010: op = OP_WIDTH'(3);
      3'b011: op = OP_WIDTH'(4);
      3'b100: op = OP_WIDTH'(5);
      3'b101: op = b30 ? OP_WIDTH'(7) : OP_WIDTH'(6);
      3'b110: op = OP_WIDTH'(8);
      default: op = OP_WIDTH'(9);
    endcase
    return op;
  endfunction

  always_comb begin
    imm_src = 3'b000;
    case (opcode)
      OP_STORE:  imm_src = 3'b001;
      OP_BRANCH: imm_src = 3'b010;
      OP_JAL:    imm_src = 3'b011;
      default:   imm_src = 3'b000;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    alu_ctrl   = ALU_ADD;
    src_a      = 2'b00;
    src_b      = 2'b00;
    result_src = 2'b00;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    retire     = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        src_b      = 2'b10;
        result_src = 2'b10;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // OldPC + imm lands in ALUOut as the branch target.
        src_a = 2'b01;
        src_b = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECR: begin
        src_a    = 2'b10;
        alu_ctrl = alu_decode(funct3, funct7_b5, 1'b1);
        state_d  = S_ALUWB;
      end
      S_EXECI: begin
        src_a    = 2'b10;
        src_b    = 2'b01;
        alu_ctrl = alu_decode(funct3, funct7_b5, 1'b0);
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        src_a    = 2'b10;
        alu_ctrl = ALU_SUB;
        case (funct3)
          3'b000: begin
            pc_write = bus.Zero;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          3'b001: begin
            pc_write = ~bus.Zero;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_ERROR;
        endcase
      end
      S_JAL: begin
        // PC <- target from ALUOut while the ALU forms OldPC+4 for the link write.
        src_a    = 2'b01;
        src_b    = 2'b10;
        pc_write = 1'b1;
        state_d  = S_ALUWB;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  assign cnt_d     = retire ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  assign illegal_d = illegal_q | (state_d == S_ERROR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.ALUControl   = alu_ctrl;
  assign bus.ALUSrcA      = src_a;
  assign bus.ALUSrcB      = src_b;
  assign bus.ResultSrc    = result_src;
  assign bus.AdrSrc       = adr_src;
  assign bus.ImmSrc       = imm_src;
  // Enables are masked combinationally so nothing is written while rst is held.
  assign bus.IRWrite      = ir_write  & ~rst;
  assign bus.PCWrite      = pc_write  & ~rst;
  assign bus.RegWrite     = reg_write & ~rst;
  assign bus.MemWrite     = mem_write & ~rst;
  assign bus.IllegalInstr = illegal_q;
  assign bus.InstrCount   = cnt_q;

endmodule
